// File: rtl/mem_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_arbiter_if
//  Purpose  : Bundles the two client request/response ports and the single
//             memory-controller request/response port of mem_req_arbiter.
//  Modports :
//    master - arbiter view: samples client requests and controller
//             responses; drives client stall/response and controller request.
//    slave  - environment view (clients + controller model), mirror image.
//  Signals  :
//    cN_valid/addr/data/rw/id   client N request            (N = 0, 1)
//    cN_stall                   client N request FIFO full
//    cN_rdata/rid/rvalid        client N response
//    mem_valid/addr/data/rw/id  request to the controller
//    mem_stall                  controller back-pressure
//    mem_rdata/rid/rvalid       controller response
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_req_arbiter_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 32,
  parameter int CLIENT_ID_BITS = 3
);

  // Client 0
  logic                      c0_valid;
  logic [ADDR_WIDTH-1:0]     c0_addr;
  logic [LINE_WIDTH-1:0]     c0_data;
  logic                      c0_rw;
  logic [CLIENT_ID_BITS-1:0] c0_id;
  logic                      c0_stall;
  logic [LINE_WIDTH-1:0]     c0_rdata;
  logic [CLIENT_ID_BITS-1:0] c0_rid;
  logic                      c0_rvalid;

  // Client 1
  logic                      c1_valid;
  logic [ADDR_WIDTH-1:0]     c1_addr;
  logic [LINE_WIDTH-1:0]     c1_data;
  logic                      c1_rw;
  logic [CLIENT_ID_BITS-1:0] c1_id;
  logic                      c1_stall;
  logic [LINE_WIDTH-1:0]     c1_rdata;
  logic [CLIENT_ID_BITS-1:0] c1_rid;
  logic                      c1_rvalid;

  // Memory-controller side; ID carries the source client in its MSB
  logic                      mem_valid;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [LINE_WIDTH-1:0]     mem_data;
  logic                      mem_rw;
  logic [CLIENT_ID_BITS:0]   mem_id;
  logic                      mem_stall;
  logic [LINE_WIDTH-1:0]     mem_rdata;
  logic [CLIENT_ID_BITS:0]   mem_rid;
  logic                      mem_rvalid;

  modport master (
    input  c0_valid, c0_addr, c0_data, c0_rw, c0_id,
    output c0_stall, c0_rdata, c0_rid, c0_rvalid,
    input  c1_valid, c1_addr, c1_data, c1_rw, c1_id,
    output c1_stall, c1_rdata, c1_rid, c1_rvalid,
    output mem_valid, mem_addr, mem_data, mem_rw, mem_id,
    input  mem_stall, mem_rdata, mem_rid, mem_rvalid
  );

  modport slave (
    output c0_valid, c0_addr, c0_data, c0_rw, c0_id,
    input  c0_stall, c0_rdata, c0_rid, c0_rvalid,
    output c1_valid, c1_addr, c1_data, c1_rw, c1_id,
    input  c1_stall, c1_rdata, c1_rid, c1_rvalid,
    input  mem_valid, mem_addr, mem_data, mem_rw, mem_id,
    output mem_stall, mem_rdata, mem_rid, mem_rvalid
  );

endinterface
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_arbiter
//  Purpose  : Two-client request arbiter in front of the DDR controller
//             wrapper. Each client owns a small request FIFO with a
//             registered full flag (cN_stall). One FIFO head is issued per
//             cycle while the controller is not stalling; responses are
//             registered and steered back by the source bit in the ID MSB.
//  Ports    :
//    clk    in  clock
//    reset  in  asynchronous active-low reset
//    bus    mem_req_arbiter_if.master (client and controller ports)
//  Config   : `MEM_REQ_ARBITER_RR_EN defined   -> round-robin arbitration
//             `MEM_REQ_ARBITER_RR_EN undefined -> fixed priority, client 0
//  Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int FIFO_INDEX_BITS = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_WIDTH      = 32,
  parameter int CLIENT_ID_BITS  = 3
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_arbiter_if.master bus
);

  localparam int                         c_DEPTH   = 1 << FIFO_INDEX_BITS;
  localparam logic [FIFO_INDEX_BITS-1:0] c_PTR_ONE = FIFO_INDEX_BITS'(1);

  // --------------------------------------------------------------------------
  // Client ports gathered into arrays so both FIFOs share one generate body
  // --------------------------------------------------------------------------
  logic [1:0]                w_valid;
  logic [ADDR_WIDTH-1:0]     w_addr    [2];
  logic [LINE_WIDTH-1:0]     w_data    [2];
  logic [1:0]                w_rw;
  logic [CLIENT_ID_BITS-1:0] w_id      [2];

  assign w_valid   = {bus.c1_valid, bus.c0_valid};
  assign w_addr[0] = bus.c0_addr;
  assign w_addr[1] = bus.c1_addr;
  assign w_data[0] = bus.c0_data;
  assign w_data[1] = bus.c1_data;
  assign w_rw      = {bus.c1_rw, bus.c0_rw};
  assign w_id[0]   = bus.c0_id;
  assign w_id[1]   = bus.c1_id;

  // Per-client FIFO status and head entry
  logic [1:0]                w_push;
  logic [1:0]                w_pop;
  logic [1:0]                w_empty;
  logic [1:0]                w_full;
  logic [ADDR_WIDTH-1:0]     w_head_addr [2];
  logic [LINE_WIDTH-1:0]     w_head_data [2];
  logic [1:0]                w_head_rw;
  logic [CLIENT_ID_BITS-1:0] w_head_id   [2];

  // Per-client registered response
  logic [1:0]                w_rvalid;
  logic [LINE_WIDTH-1:0]     w_rdata     [2];
  logic [CLIENT_ID_BITS-1:0] w_rid       [2];

  // Source client of the incoming response
  logic w_rsp_src;
  assign w_rsp_src = bus.mem_rid[CLIENT_ID_BITS];

  // --------------------------------------------------------------------------
  // Request FIFOs and response registers, one instance per client
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_client
    localparam logic c_SRC = 1'(gi);

    logic [FIFO_INDEX_BITS-1:0] head_q, head_d;
    logic [FIFO_INDEX_BITS-1:0] tail_q, tail_d;
    logic                       full_q, full_d;
    logic [ADDR_WIDTH-1:0]      addr_q [c_DEPTH];
    logic [LINE_WIDTH-1:0]      data_q [c_DEPTH];
    logic                       rw_q   [c_DEPTH];
    logic [CLIENT_ID_BITS-1:0]  id_q   [c_DEPTH];

    logic                       rvalid_q, rvalid_d;
    logic [LINE_WIDTH-1:0]      rdata_q,  rdata_d;
    logic [CLIENT_ID_BITS-1:0]  rid_q,    rid_d;

    // Pushes are gated by the registered full flag only, so the stall seen
    // by the client never depends on its own valid in the same cycle.
    assign w_push[gi]  = w_valid[gi] & ~full_q;
    assign w_empty[gi] = (head_q == tail_q) & ~full_q;
    assign w_full[gi]  = full_q;

    always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      full_d = full_q;
      if (w_push[gi]) begin
        tail_d = tail_q + c_PTR_ONE;
      end
      if (w_pop[gi]) begin
        head_d = head_q + c_PTR_ONE;
      end
      // Full can only be reached by a push; any pop without a push frees a
      // slot. Push+pop keeps occupancy, compared against the moved head.
      if (w_push[gi] && !w_pop[gi]) begin
        full_d = (tail_d == head_q);
      end else if (w_push[gi] && w_pop[gi]) begin
        full_d = (tail_d == head_d);
      end else if (w_pop[gi]) begin
        full_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        head_q <= '0;
        tail_q <= '0;
        full_q <= 1'b0;
        for (int i = 0; i < c_DEPTH; i++) begin
          addr_q[i] <= '0;
          data_q[i] <= '0;
          rw_q[i]   <= 1'b0;
          id_q[i]   <= '0;
        end
      end else begin
        head_q <= head_d;
        tail_q <= tail_d;
        full_q <= full_d;
        if (w_push[gi]) begin
          addr_q[tail_q] <= w_addr[gi];
          data_q[tail_q] <= w_data[gi];
          rw_q[tail_q]   <= w_rw[gi];
          id_q[tail_q]   <= w_id[gi];
        end
      end
    end

    assign w_head_addr[gi] = addr_q[head_q];
    assign w_head_data[gi] = data_q[head_q];
    assign w_head_rw[gi]   = rw_q[head_q];
    assign w_head_id[gi]   = id_q[head_q];

    // Response steering: strobe only the addressed client; the other client
    // keeps its last data/ID and sees its strobe drop.
    always_comb begin
      rvalid_d = bus.mem_rvalid & (w_rsp_src == c_SRC);
      rdata_d  = rdata_q;
      rid_d    = rid_q;
      if (rvalid_d) begin
        rdata_d = bus.mem_rdata;
        rid_d   = bus.mem_rid[CLIENT_ID_BITS-1:0];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
        rid_q    <= '0;
      end else begin
        rvalid_q <= rvalid_d;
        rdata_q  <= rdata_d;
        rid_q    <= rid_d;
      end
    end

    assign w_rvalid[gi] = rvalid_q;
    assign w_rdata[gi]  = rdata_q;
    assign w_rid[gi]    = rid_q;
  end

  // --------------------------------------------------------------------------
  // Arbitration. w_gnt is the client that is (or, under stall, would be)
  // granted. With both FIFOs empty it points at client 0, whose head is all
  // zeros straight after reset.
  // --------------------------------------------------------------------------
  logic w_gnt;
  logic w_any;
  logic w_issue;

  assign w_any   = ~(&w_empty);
  assign w_issue = w_any & ~bus.mem_stall;

`ifdef MEM_REQ_ARBITER_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (!w_empty[0] && !w_empty[1]) begin
      w_gnt = ~last_grant_q;
    end else begin
      w_gnt = w_empty[0] & ~w_empty[1];
    end
  end

  // Only an actual pop moves the round-robin pointer
  always_comb begin
    last_grant_d = last_grant_q;
    if (w_issue) begin
      last_grant_d = w_gnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: client 1 is served only while client 0 is empty
  assign w_gnt = w_empty[0] & ~w_empty[1];
`endif

  assign w_pop = {w_issue & w_gnt, w_issue & ~w_gnt};

  // --------------------------------------------------------------------------
  // Outputs. mem_valid depends on registered FIFO state and mem_stall only,
  // so a request accepted at one edge is visible no earlier than the next
  // cycle.
  // --------------------------------------------------------------------------
  assign bus.mem_valid = w_issue;
  assign bus.mem_addr  = w_head_addr[w_gnt];
  assign bus.mem_data  = w_head_data[w_gnt];
  assign bus.mem_rw    = w_head_rw[w_gnt];
  assign bus.mem_id    = {w_gnt, w_head_id[w_gnt]};

  assign bus.c0_stall  = w_full[0];
  assign bus.c1_stall  = w_full[1];
  assign bus.c0_rvalid = w_rvalid[0];
  assign bus.c1_rvalid = w_rvalid[1];
  assign bus.c0_rdata  = w_rdata[0];
  assign bus.c1_rdata  = w_rdata[1];
  assign bus.c0_rid    = w_rid[0];
  assign bus.c1_rid    = w_rid[1];

endmodule
`default_nettype wire
